// File: rtl/team_00_wbm_pkg.sv
// team_00_wbm_pkg: shared state encoding, request bundle and address
// alignment helper for the team_00 Wishbone single-transfer master.
package team_00_wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

  // One latched bus request; also used as the registered master-port bundle.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wbm_req_t;

  localparam logic [31:0] WB_ADR_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam wbm_req_t WBM_REQ_ZERO = '{we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0};

  // Word-align a byte address for the bus (byte lanes come from SEL_O).
  function automatic logic [31:0] wb_align(input logic [31:0] adr);
    return adr & WB_ADR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/team_00_wbm_timeout.sv
// team_00_wbm_timeout: saturating cycle counter for the bus-cycle watchdog.
// expired is high while the count sits at TIMEOUT_CYCLES-1; a zero
// TIMEOUT_CYCLES keeps expired low so the master waits forever.
module team_00_wbm_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned      LAST_I  = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LAST_C  = LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles, clear on request, hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 32'd0) && (count_r == LAST_C);

endmodule

// File: rtl/team_00_wb_master.sv
// team_00_wb_master: turns one valid/ready user request into a single
// Wishbone classic cycle and returns read data or a timeout error on a
// response channel that is held until the user takes it.
module team_00_wb_master
  import team_00_wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  wbm_state_e  state_r, next_state_s;
  wbm_req_t    bus_r, bus_nxt_s;
  logic        cyc_r, cyc_nxt_s;
  logic        req_ready_r, req_ready_nxt_s;
  logic        rsp_valid_r, rsp_valid_nxt_s;
  logic [31:0] rsp_dat_r, rsp_dat_nxt_s;
  logic        rsp_err_r, rsp_err_nxt_s;
  logic        cnt_clr_s;
  logic        cnt_en_s;
  logic        tmo_expired_s;

  assign cnt_en_s = (state_r == BUSY);

  team_00_wbm_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (tmo_expired_s)
  );

  // Next state and next value of every registered output.
  always_comb begin
    next_state_s    = state_r;
    bus_nxt_s       = bus_r;
    cyc_nxt_s       = cyc_r;
    req_ready_nxt_s = req_ready_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_dat_nxt_s   = rsp_dat_r;
    rsp_err_nxt_s   = rsp_err_r;
    cnt_clr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          next_state_s    = BUSY;
          bus_nxt_s.we    = req_we;
          bus_nxt_s.adr   = wb_align(req_adr);
          bus_nxt_s.dat   = req_we ? req_dat : 32'h0;
          bus_nxt_s.sel   = req_sel;
          cyc_nxt_s       = 1'b1;
          req_ready_nxt_s = 1'b0;
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end
      BUSY: begin
        if (ACK_I) begin
          // ACK has priority over a watchdog expiry on the same edge.
          next_state_s    = RESP;
          bus_nxt_s       = WBM_REQ_ZERO;
          cyc_nxt_s       = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_dat_nxt_s   = bus_r.we ? 32'h0 : DAT_I;
          rsp_err_nxt_s   = 1'b0;
        end else if (tmo_expired_s) begin
          next_state_s    = RESP;
          bus_nxt_s       = WBM_REQ_ZERO;
          cyc_nxt_s       = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_dat_nxt_s   = 32'h0;
          rsp_err_nxt_s   = 1'b1;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          next_state_s    = IDLE;
          rsp_valid_nxt_s = 1'b0;
          rsp_dat_nxt_s   = 32'h0;
          rsp_err_nxt_s   = 1'b0;
          req_ready_nxt_s = 1'b1;
          cnt_clr_s       = 1'b1;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s    = IDLE;
        bus_nxt_s       = WBM_REQ_ZERO;
        cyc_nxt_s       = 1'b0;
        req_ready_nxt_s = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        rsp_dat_nxt_s   = 32'h0;
        rsp_err_nxt_s   = 1'b0;
        cnt_clr_s       = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer or pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      bus_r       <= WBM_REQ_ZERO;
      cyc_r       <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'h0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      bus_r       <= bus_nxt_s;
      cyc_r       <= cyc_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_dat_r   <= rsp_dat_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign rsp_err   = rsp_err_r;
  assign ADR_O     = bus_r.adr;
  assign DAT_O     = bus_r.dat;
  assign SEL_O     = bus_r.sel;
  assign WE_O      = bus_r.we;
  assign STB_O     = cyc_r;
  assign CYC_O     = cyc_r;

endmodule

// File: tb/tb_team_00_wb_master.sv
// tb_team_00_wb_master: directed checks of the Wishbone master with a
// 4-cycle watchdog: zero-wait write, waited read, timeout, response
// backpressure and reset in the middle of a bus cycle.
module tb_team_00_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O, STB_O, CYC_O, ACK_I;

  int n_chk  = 0;
  int n_pass = 0;

  team_00_wb_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
  endtask

  initial begin
    rst_i = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = 32'h0; req_dat = 32'h0;
    req_sel = 4'h0; rsp_ready = 1'b0; DAT_I = 32'h0; ACK_I = 1'b0;

    // ---------------- reset state
    tick(); tick();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_cyc",       {31'h0, CYC_O},     32'h0);
    chk("rst_stb",       {31'h0, STB_O},     32'h0);
    chk("rst_adr",       ADR_O,              32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_dat",   rsp_dat,            32'h0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // ---------------- zero-wait write
    drive_req(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("wr_cyc",   {31'h0, CYC_O},     32'h1);
    chk("wr_stb",   {31'h0, STB_O},     32'h1);
    chk("wr_we",    {31'h0, WE_O},      32'h1);
    chk("wr_dat_o", DAT_O,              32'hDEAD_BEEF);
    chk("wr_adr_o", ADR_O,              32'h3000_0004);
    chk("wr_sel_o", {28'h0, SEL_O},     32'hF);
    chk("wr_ready", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0; ACK_I = 1'b1; DAT_I = 32'hFFFF_FFFF;
    tick();
    ACK_I = 1'b0;
    chk("wr_cyc_drop", {31'h0, CYC_O},     32'h0);
    chk("wr_we_drop",  {31'h0, WE_O},      32'h0);
    chk("wr_dat_zero", DAT_O,              32'h0);
    chk("wr_rsp_vld",  {31'h0, rsp_valid}, 32'h1);
    chk("wr_rsp_err",  {31'h0, rsp_err},   32'h0);
    chk("wr_rsp_dat",  rsp_dat,            32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_done_vld",   {31'h0, rsp_valid}, 32'h0);
    chk("wr_done_ready", {31'h0, req_ready}, 32'h1);

    // ---------------- read, ACK on 4th BUSY cycle (same edge as watchdog)
    drive_req(1'b0, 32'h3000_0013, 32'hAAAA_5555, 4'h3);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rd_cyc_%0d", i), {31'h0, CYC_O},  32'h1);
      chk($sformatf("rd_adr_%0d", i), ADR_O,           32'h3000_0010);
      chk($sformatf("rd_sel_%0d", i), {28'h0, SEL_O},  32'h3);
      chk($sformatf("rd_dto_%0d", i), DAT_O,           32'h0);
      if (i == 4) begin
        ACK_I = 1'b1; DAT_I = 32'h1234_5678;
      end else begin
        DAT_I = 32'h9999_9999;
      end
      tick();
    end
    ACK_I = 1'b0; DAT_I = 32'h0;
    chk("rd_cyc_drop", {31'h0, CYC_O},     32'h0);
    chk("rd_adr_drop", ADR_O,              32'h0);
    chk("rd_rsp_vld",  {31'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_dat",  rsp_dat,            32'h1234_5678);
    chk("rd_rsp_err",  {31'h0, rsp_err},   32'h0);

    // ---------------- response backpressure with a pending request
    drive_req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ACK_I = 1'b1; else ACK_I = 1'b0;
      DAT_I = 32'h7777_0000;
      tick();
      chk($sformatf("bp_vld_%0d", i),   {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("bp_dat_%0d", i),   rsp_dat,            32'h1234_5678);
      chk($sformatf("bp_ready_%0d", i), {31'h0, req_ready}, 32'h0);
      chk($sformatf("bp_cyc_%0d", i),   {31'h0, CYC_O},     32'h0);
    end
    ACK_I = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rel_vld",   {31'h0, rsp_valid}, 32'h0);
    chk("bp_rel_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_rel_cyc",   {31'h0, CYC_O},     32'h0);

    // ---------------- timeout on a read (request still held, accepted now)
    DAT_I = 32'h5A5A_5A5A;
    tick();
    req_valid = 1'b0;
    chk("to_adr", ADR_O, 32'h3000_0020);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_cyc_%0d", i), {31'h0, CYC_O}, 32'h1);
      tick();
    end
    chk("to_cyc_drop", {31'h0, CYC_O},     32'h0);
    chk("to_rsp_vld",  {31'h0, rsp_valid}, 32'h1);
    chk("to_rsp_err",  {31'h0, rsp_err},   32'h1);
    chk("to_rsp_dat",  rsp_dat,            32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_done_vld", {31'h0, rsp_valid}, 32'h0);

    // ---------------- reset in the middle of a waited read
    drive_req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("rb_cyc_1", {31'h0, CYC_O}, 32'h1);
    tick();
    chk("rb_cyc_2", {31'h0, CYC_O}, 32'h1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rb_cyc_rst", {31'h0, CYC_O},     32'h0);
    chk("rb_stb_rst", {31'h0, STB_O},     32'h0);
    chk("rb_vld_rst", {31'h0, rsp_valid}, 32'h0);
    ACK_I = 1'b1; DAT_I = 32'hCAFE_0001;
    tick();
    ACK_I = 1'b0;
    chk("rb_late_ack_vld", {31'h0, rsp_valid}, 32'h0);
    chk("rb_late_ack_cyc", {31'h0, CYC_O},     32'h0);
    chk("rb_ready",        {31'h0, req_ready}, 32'h1);
    tick();
    chk("rb_idle_vld", {31'h0, rsp_valid}, 32'h0);

    // ---------------- new write after reset completes normally
    drive_req(1'b1, 32'h3000_0044, 32'h1111_2222, 4'hC);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("nw_cyc_%0d", i), {31'h0, CYC_O}, 32'h1);
      chk($sformatf("nw_dto_%0d", i), DAT_O,          32'h1111_2222);
      chk($sformatf("nw_sel_%0d", i), {28'h0, SEL_O}, 32'hC);
      if (i == 4) ACK_I = 1'b1; else ACK_I = 1'b0;
      tick();
    end
    ACK_I = 1'b0;
    chk("nw_rsp_vld", {31'h0, rsp_valid}, 32'h1);
    chk("nw_rsp_err", {31'h0, rsp_err},   32'h0);
    chk("nw_rsp_dat", rsp_dat,            32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("nw_done_ready", {31'h0, req_ready}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
